// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline registers.
//   - Default control/data widths for each stage boundary (IF/ID, ID/EX,
//     EX/MEM, MEM/WB).
//   - Bit offsets of the fields packed into the control vector.
// No ports; imported by pipe_entry and pipe_stage_reg.
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Which boundary a stage register sits on.
    typedef enum logic [1:0] {
        BND_IF_ID  = 2'd0,
        BND_ID_EX  = 2'd1,
        BND_EX_MEM = 2'd2,
        BND_MEM_WB = 2'd3
    } stage_boundary_e;

    // Default widths per boundary.
    localparam int IF_ID_CTRL_W  = 16;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int ID_EX_DATA_W  = 96;
    localparam int EX_MEM_CTRL_W = 16;
    localparam int EX_MEM_DATA_W = 80;
    localparam int MEM_WB_CTRL_W = 16;
    localparam int MEM_WB_DATA_W = 40;

    // Control-vector field offsets. Every field is zero in a bubble, so a
    // zero control vector is always a harmless no-op.
    localparam int CTRL_REG_WR    = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_TO_RG = 3;
    localparam int CTRL_ALU_OP_LO = 4;
    localparam int CTRL_ALU_OP_W  = 4;
    localparam int CTRL_ALU_SRC   = 8;
    localparam int CTRL_BRANCH    = 9;
    localparam int CTRL_JUMP      = 10;

    // Default stall-counter width.
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One storage slot of a pipeline stage: a valid bit plus a ctrl/data register.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 synchronous clear of the valid bit (wins over load)
//   load                  capture load_ctrl/load_data and set valid
//   drain                 clear valid (ignored when load is also high)
//   load_ctrl, load_data  value captured on load
//   valid, ctrl, data     stored contents
// ---------------------------------------------------------------------------
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic              drain,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Valid bit: flush beats everything, a new load beats a drain so that
    // a slot being emptied and refilled in the same cycle stays valid.
    // The payload is only rewritten on an actual (unflushed) load; reset
    // clears it so a freshly reset stage shows all-zero outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
                ctrl  <= load_ctrl;
                data  <= load_data;
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Elastic pipeline stage register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush with bubble insertion and a
// saturating stall-cycle counter.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   flush                         kill held entries and the current input beat
//   in_valid/in_ready             upstream handshake
//   in_ctrl/in_data               upstream control vector and payload
//   out_valid/out_ready           downstream handshake
//   out_ctrl/out_data             downstream control vector (zero in bubbles)
//                                 and payload
//   stall_cnt                     cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = STALL_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic [CTRL_W-1:0] main_src_ctrl;
    logic [DATA_W-1:0] main_src_data;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic              skid_load;

            // Ready comes straight from a flop, cutting the ready path.
            assign in_ready = !skid_valid;

            // A beat only parks in skid when main is occupied and held.
            assign skid_load = !skid_valid && in_xfer && main_valid && !out_ready;

            // With skid occupied, in_ready is low, so main can only be
            // refilled from skid; otherwise main takes the new beat when it
            // is empty or draining this cycle.
            assign main_load     = skid_valid ? out_xfer
                                              : (in_xfer && (!main_valid || out_ready));
            assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
            assign main_src_data = skid_valid ? skid_data : in_data;

            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk       (clk),
                .reset_n   (reset_n),
                .flush     (flush),
                .load      (skid_load),
                .drain     (out_xfer),
                .load_ctrl (in_ctrl),
                .load_data (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );
        end else begin : g_single
            // Single register: accept whenever the slot is empty or emptying.
            assign in_ready      = !main_valid || out_ready;
            assign main_load     = in_xfer;
            assign main_src_ctrl = in_ctrl;
            assign main_src_data = in_data;
        end
    endgenerate

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .load      (main_load),
        .drain     (out_xfer),
        .load_ctrl (main_src_ctrl),
        .load_data (main_src_data),
        .valid     (main_valid),
        .ctrl      (main_ctrl),
        .data      (main_data)
    );

    // Bubbles carry an all-zero control vector so that no write-enable can
    // leak out of an empty or flushed stage.
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    // Stall counter: counts cycles where downstream refuses a present beat,
    // saturating instead of wrapping. Flush does not touch it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
